ram_arbiter: RTL and testbench

- Shares the single-port data RAM (10-bit address, 32-bit data, Store/Clear controls) between two requesters: port 0 (CPU data path) and port 1 (loader/debug).
- Uses a round-robin req/gnt handshake with a registered grant and registered read data.
- Can optionally sweep-initialise every RAM word after reset, before any grant is issued.
- Sits between the requesters and the ram instance; no requester drives the RAM directly.

---
 rtl/ram_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port data RAM between two requesters: port 0 (CPU data
//   path) and port 1 (loader/debug). Round-robin req/gnt handshake with a
//   registered grant, registered RAM drive and registered read data.
//
//   Optional feature (macro RAM_ARB_INIT_EN): after reset the block sweeps
//   every RAM word with INIT_VALUE, one word per cycle, before any grant.
//   Without the macro the INIT state and sweep counter do not exist and reset
//   goes straight to IDLE, leaving the RAM untouched.
//
// Ports
//   clk, Clear_n        clock, synchronous active-low reset
//   reqN/weN/addrN/wdataN   request from port N (we qualified by req)
//   gntN                one-cycle pulse: the RAM is driven for port N this cycle
//   rvalidN, rdata      one-cycle pulse: rdata holds port N's read result
//   ram_addr/ram_din/ram_store/ram_clear  RAM controls (ram_clear held 0)
//   ram_dout            RAM read data, valid the cycle after ram_addr
//   busy                high whenever the arbiter is not idle
//
// All outputs are flops loaded from the next-state logic, so reset forces
// every output to 0 regardless of the state being entered.
module ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
`ifdef RAM_ARB_INIT_EN
  ,
  parameter logic [DATA_W-1:0] INIT_VALUE = {DATA_W{1'b0}}
`endif
) (
  input  logic              clk,
  input  logic              Clear_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_store,
  output logic              ram_clear,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
`ifdef RAM_ARB_INIT_EN
    ,
    S_INIT   = 2'd3
`endif
  } state_t;

`ifdef RAM_ARB_INIT_EN
  localparam state_t RESET_STATE = S_INIT;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t              state_q, state_d;
  logic                sel_q, sel_d;      // selected port (0/1)
  logic                we_q, we_d;        // selected access is a write
  logic                pref_q, pref_d;    // port preferred on contention
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                ram_store_q, ram_store_d;
  logic                busy_q, busy_d;
`ifdef RAM_ARB_INIT_EN
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
`endif

  // Port 1 wins when it is the only requester, or when both request and
  // port 1 holds the preference.
  logic pick1;
  assign pick1 = req1 & (~req0 | pref_q);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    we_d        = we_q;
    pref_d      = pref_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata_d     = rdata_q;
    ram_addr_d  = {ADDR_W{1'b0}};
    ram_din_d   = {DATA_W{1'b0}};
    ram_store_d = 1'b0;
    busy_d      = 1'b0;
`ifdef RAM_ARB_INIT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
`ifdef RAM_ARB_INIT_EN
      S_INIT: begin
        // Present word cnt_q next cycle; the last word hands over to IDLE.
        ram_addr_d  = cnt_q;
        ram_din_d   = INIT_VALUE;
        ram_store_d = 1'b1;
        busy_d      = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = S_IDLE;
        end
      end
`endif
      S_IDLE: begin
        if (req0 || req1) begin
          // Preference only moves when both ports actually contended.
          if (req0 && req1) begin
            pref_d = ~pick1;
          end
          sel_d       = pick1;
          we_d        = pick1 ? we1 : we0;
          ram_addr_d  = pick1 ? addr1 : addr0;
          ram_din_d   = pick1 ? wdata1 : wdata0;
          ram_store_d = pick1 ? we1 : we0;
          gnt0_d      = ~pick1;
          gnt1_d      = pick1;
          busy_d      = 1'b1;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
          busy_d  = 1'b1;
        end
      end
      S_RESP: begin
        // ram_dout now reflects the address driven during ACCESS.
        rdata_d   = ram_dout;
        rvalid0_d = ~sel_q;
        rvalid1_d = sel_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Clear_n) begin
      state_q     <= RESET_STATE;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      pref_q      <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
      ram_addr_q  <= {ADDR_W{1'b0}};
      ram_din_q   <= {DATA_W{1'b0}};
      ram_store_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RAM_ARB_INIT_EN
      cnt_q       <= {ADDR_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      pref_q      <= pref_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_store_q <= ram_store_d;
      busy_q      <= busy_d;
`ifdef RAM_ARB_INIT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_store = ram_store_q;
  assign ram_clear = 1'b0;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized batches. A
// reference model turns each batch of per-port request lists into expected
// grants and read responses (round-robin rule, latency arithmetic, a plain
// memory array); a monitor pops and compares them as the DUT emits them.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct packed {
    logic          p;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   t;
  } gexp_t;

  typedef struct packed {
    logic          p;
    logic [DW-1:0] data;
    logic [31:0]   t;
  } rexp_t;

  logic          clk = 1'b0;
  logic          Clear_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_store, ram_clear, busy;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  gexp_t gnt_exp[$];
  rexp_t rd_exp[$];
  txn_t  pend0[$];
  txn_t  pend1[$];

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          pref_m = 1'b0;
  logic [DW-1:0] last_rd = '0;

  ram_arbiter dut (
    .clk(clk), .Clear_n(Clear_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_store(ram_store), .ram_clear(ram_clear), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // RAM instance model: registered read, write on Store, preloaded at the
  // first clock edge (during reset).
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= pat(i);
      mem_loaded <= 1'b1;
    end else begin
      if (ram_store) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every grant / read response against the scoreboard.
  always @(negedge clk) begin : monitor
    gexp_t ge;
    rexp_t re;
    if (Clear_n) begin
      if (gnt0 || gnt1) begin
        if (gnt_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL gnt_unexpected: got gnt0=%0b gnt1=%0b, required none", gnt0, gnt1);
        end else begin
          ge = gnt_exp.pop_front();
          $display("cycle %0d: gnt port%0d we=%0b addr=%h din=%h", cyc, ge.p, ge.we, ge.addr, ram_din);
          check("gnt_port", 32'({gnt1, gnt0}), ge.p ? 32'd2 : 32'd1);
          check("gnt_cycle", 32'(cyc), ge.t);
          check("ram_addr", 32'(ram_addr), 32'(ge.addr));
          check("ram_store", 32'(ram_store), 32'(ge.we));
          if (ge.we) check("ram_din", ram_din, ge.data);
          check("busy_access", 32'(busy), 32'd1);
          check("ram_clear", 32'(ram_clear), 32'd0);
        end
      end
      if (rvalid0 || rvalid1) begin
        if (rd_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b, required none", rvalid0, rvalid1);
        end else begin
          re = rd_exp.pop_front();
          $display("cycle %0d: rvalid port%0d rdata=%h", cyc, re.p, rdata);
          check("rvalid_port", 32'({rvalid1, rvalid0}), re.p ? 32'd2 : 32'd1);
          check("rvalid_cycle", 32'(cyc), re.t);
          check("rdata", rdata, re.data);
        end
      end
    end
  end

  // Present the head of each port's list; idle ports get random junk.
  task automatic drive_ports();
    if (pend0.size() != 0) begin
      req0 = 1'b1; we0 = pend0[0].we; addr0 = pend0[0].addr; wdata0 = pend0[0].data;
    end else begin
      req0 = 1'b0; we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = $urandom;
    end
    if (pend1.size() != 0) begin
      req1 = 1'b1; we1 = pend1[0].we; addr1 = pend1[0].addr; wdata1 = pend1[0].data;
    end else begin
      req1 = 1'b0; we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = $urandom;
    end
  endtask

  // Reference model: both lists are requested continuously from the next
  // edge on; each decision picks the lone requester or, on contention, the
  // preferred port and then flips the preference. Writes occupy 2 cycles,
  // reads 3, and read data appears 2 cycles after the grant.
  task automatic model_batch();
    txn_t  m0[$];
    txn_t  m1[$];
    txn_t  x;
    gexp_t ge;
    rexp_t re;
    logic  p;
    int    t;
    m0 = pend0;
    m1 = pend1;
    t = cyc + 1;
    while (m0.size() != 0 || m1.size() != 0) begin
      if (m0.size() != 0 && m1.size() != 0) begin
        p = pref_m;
        pref_m = ~pref_m;
      end else begin
        p = (m0.size() == 0);
      end
      x = p ? m1.pop_front() : m0.pop_front();
      ge = '{p: p, we: x.we, addr: x.addr, data: x.data, t: 32'(t)};
      gnt_exp.push_back(ge);
      if (x.we) begin
        ref_mem[x.addr] = x.data;
        t += 2;
      end else begin
        re = '{p: p, data: ref_mem[x.addr], t: 32'(t + 2)};
        rd_exp.push_back(re);
        last_rd = ref_mem[x.addr];
        t += 3;
      end
    end
  endtask

  task automatic run_batch();
    int budget;
    int guard;
    budget = 3 * (pend0.size() + pend1.size()) + 10;
    guard = 0;
    model_batch();
    drive_ports();
    while (1) begin
      @(negedge clk);
      if (gnt0 && pend0.size() != 0) pend0.delete(0);
      if (gnt1 && pend1.size() != 0) pend1.delete(0);
      drive_ports();
      if (pend0.size() == 0 && pend1.size() == 0 && gnt_exp.size() == 0 && rd_exp.size() == 0) break;
      guard++;
      if (guard > budget) begin
        total++; bad++;
        $display("FAIL batch_timeout: got %0d grants and %0d reads outstanding, required 0", gnt_exp.size(), rd_exp.size());
        pend0.delete(); pend1.delete(); gnt_exp.delete(); rd_exp.delete();
        drive_ports();
        break;
      end
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_strobes", 32'({gnt0, gnt1, rvalid0, rvalid1}), 32'd0);
    check("rdata_hold", rdata, last_rd);
  endtask

  // Hold reset 3 cycles with req0 asserted; every output must read 0.
  task automatic do_reset();
    Clear_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, ram_store, ram_clear, busy}), 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_ram_addr", 32'(ram_addr), 32'd0);
      check("reset_ram_din", ram_din, 32'd0);
    end
    Clear_n = 1'b1;
    req0 = 1'b0;
    pref_m = 1'b0;
    last_rd = '0;
`ifdef RAM_ARB_INIT_EN
    req1 = 1'b1;
    for (int k = 0; k < (1 << AW); k++) begin
      @(negedge clk);
      check("init_word", 32'({busy, ram_store, ram_addr}), 32'({2'b11, AW'(k)}));
      check("init_din", ram_din, 32'd0);
      if (k == (1 << AW) - 1) req1 = 1'b0;
    end
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    @(negedge clk);
    check("init_done_busy", 32'(busy), 32'd0);
`endif
  endtask

  task automatic push0(input logic we, input int a, input logic [DW-1:0] d);
    txn_t x;
    x = '{we: we, addr: AW'(a), data: d};
    pend0.push_back(x);
  endtask

  task automatic push1(input logic we, input int a, input logic [DW-1:0] d);
    txn_t x;
    x = '{we: we, addr: AW'(a), data: d};
    pend1.push_back(x);
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 15));
  endfunction

  initial begin
    int guard;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pat(i);

    do_reset();

    // Port 1 write to the top address straight after reset release, read back.
    push1(1'b1, 10'h3FF, 32'h0000_0010);
    run_batch();
    push1(1'b0, 10'h3FF, '0);
    run_batch();

    // Single write then read on port 0.
    push0(1'b1, 5, 32'hDEAD_BEEF);
    run_batch();
    push0(1'b0, 5, '0);
    run_batch();

    // Contention with both ports held: grants alternate 0,1,0,1.
    push0(1'b0, 1, '0); push0(1'b0, 1, '0);
    push1(1'b0, 2, '0); push1(1'b0, 2, '0);
    run_batch();

    // Port 1 alone right after a port 0 grant.
    push0(1'b0, 7, '0);
    run_batch();
    push1(1'b1, 9, 32'h1234_5678);
    run_batch();

    // Both ports writing the same address, then both reading it.
    push0(1'b1, 12, 32'hAAAA_0000); push1(1'b1, 12, 32'h0000_BBBB);
    run_batch();
    push0(1'b0, 12, '0); push1(1'b0, 12, '0);
    run_batch();

    // Randomized batches.
    for (int b = 0; b < 60; b++) begin
      int n0, n1;
      n0 = int'($urandom_range(0, 3));
      n1 = int'($urandom_range(0, 3));
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) push0(1'($urandom), rand_addr(), $urandom);
      for (int i = 0; i < n1; i++) push1(1'($urandom), rand_addr(), $urandom);
      run_batch();
    end

    // Reset during the RESP cycle of a read: no rvalid, rdata cleared.
    push0(1'b0, 5, '0);
    model_batch();
    drive_ports();
    guard = 0;
    while (1) begin
      @(negedge clk);
      if (gnt0) begin
        pend0.delete(0);
        drive_ports();
        break;
      end
      guard++;
      if (guard > 10) begin
        total++; bad++;
        $display("FAIL abort_gnt_timeout: got no gnt0, required gnt0");
        pend0.delete(); gnt_exp.delete();
        drive_ports();
        break;
      end
    end
    @(negedge clk);
    rd_exp.delete();
    do_reset();

    // Traffic resumes normally after the aborted read.
    push0(1'b0, 5, '0); push1(1'b1, 6, 32'hCAFE_F00D);
    run_batch();
    push1(1'b0, 6, '0);
    run_batch();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
